// File: rtl/sd_card_model.sv
// SD card slave model (4-bit bus): decodes host commands, answers R1/R2/R3/R6/R7, streams CMD17 blocks from a ROM.
// Latency: response start bit NCR sdclk cycles after command end bit; data start nibble NAC cycles after response end.
// Backpressure: none; host timing is fixed by sdclk, ROM must return rddata one rising edge after rdaddr.
// Ports: sdclk (sole clock), rstn_async (async active-low reset), sdcmdin/sdcmdout (CMD line in/out, out idles 1),
//        sddat (DAT[3:0], driven only during a data block), rdaddr {block[31:0], word[7:0]}, rddata (16-bit ROM word).
module sd_card_model #(
    parameter logic [15:0]  RCA = 16'h0013,
    parameter int           NCR = 2,
    parameter int           NAC = 2,
    parameter logic [31:0]  OCR = 32'hC0FF8000,
    parameter logic [127:0] CID = 128'h0
) (
    input  logic        sdclk,
    input  logic        rstn_async,
    input  logic        sdcmdin,
    output logic        sdcmdout,
    inout  wire  [3:0]  sddat,
    output logic [39:0] rdaddr,
    input  logic [15:0] rddata
);

    typedef enum logic [2:0] {
        RX_IDLE, RX_CMD, WAIT_NCR, TX_RESP, WAIT_NAC, TX_DATA
    } state_t;

    localparam logic [10:0] NCR_LAST = 11'(NCR - 1);
    localparam logic [10:0] NAC_LAST = 11'(NAC - 1);
    // Data block nibble index: 0 start, 1..1024 data, 1025..1040 CRC16, 1041 end.
    localparam logic [10:0] DAT_LAST = 11'd1041;

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [47:0] r48(input logic [5:0] idx, input logic [31:0] pl);
        logic [39:0] h;
        h = {2'b00, idx, pl};
        return {h, crc7_40(h), 1'b1};
    endfunction

    state_t        state, state_nxt;
    logic [10:0]   cnt;
    logic [46:0]   rx_sr;
    logic          acmd;
    logic [135:0]  resp_sr;
    logic          resp_long;
    logic          rd_pend;
    logic [15:0]   dat_sr;
    logic [3:0][15:0] crc;
    logic          cmd_q;
    logic          dat_oe;
    logic [3:0]    dat_q;

    // The 48th bit is still on sdcmdin when the command is judged, so splice it in.
    logic [47:0] cmd_word;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_ok;
    logic        cmd_done;

    assign cmd_word = {rx_sr, sdcmdin};
    assign cmd_idx  = cmd_word[45:40];
    assign cmd_arg  = cmd_word[39:8];
    assign cmd_ok   = !cmd_word[47] && cmd_word[46] && cmd_word[0]
                      && (crc7_40(cmd_word[47:8]) == cmd_word[7:1]);
    assign cmd_done = (state == RX_CMD) && (cnt == 11'd47);

    logic         has_resp;
    logic         is_long;
    logic         is_read;
    logic [135:0] resp_val;

    always_comb begin
        has_resp = 1'b0;
        is_long  = 1'b0;
        is_read  = 1'b0;
        resp_val = '1;
        case (cmd_idx)
            6'd2, 6'd10: begin
                has_resp = 1'b1;
                is_long  = 1'b1;
                resp_val = {2'b00, 6'h3F, CID[127:1], 1'b1};
            end
            6'd3: begin
                has_resp = 1'b1;
                resp_val = {r48(cmd_idx, {RCA, 16'h0500}), {88{1'b1}}};
            end
            6'd7, 6'd16, 6'd55: begin
                has_resp = 1'b1;
                resp_val = {r48(cmd_idx, 32'h0000_0900), {88{1'b1}}};
            end
            6'd8: begin
                has_resp = 1'b1;
                resp_val = {r48(cmd_idx, {20'h0, cmd_arg[11:0]}), {88{1'b1}}};
            end
            6'd17: begin
                has_resp = 1'b1;
                is_read  = 1'b1;
                resp_val = {r48(cmd_idx, 32'h0000_0900), {88{1'b1}}};
            end
            6'd41: begin
                // Only meaningful as ACMD41; a bare CMD41 is ignored.
                if (acmd) begin
                    has_resp = 1'b1;
                    resp_val = {2'b00, 6'h3F, OCR, 7'h7F, 1'b1, {88{1'b1}}};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (!sdcmdin) state_nxt = RX_CMD;
            RX_CMD:   if (cnt == 11'd47) state_nxt = (cmd_ok && has_resp) ? WAIT_NCR : RX_IDLE;
            WAIT_NCR: if (cnt == NCR_LAST) state_nxt = TX_RESP;
            TX_RESP:  if (cnt == (resp_long ? 11'd135 : 11'd47)) state_nxt = rd_pend ? WAIT_NAC : RX_IDLE;
            WAIT_NAC: if (cnt == NAC_LAST) state_nxt = TX_DATA;
            TX_DATA:  if (cnt == DAT_LAST) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge sdclk or negedge rstn_async) begin
        if (!rstn_async) state <= RX_IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge sdclk or negedge rstn_async) begin
        if (!rstn_async) begin
            cnt       <= 11'd0;
            rx_sr     <= '0;
            acmd      <= 1'b0;
            resp_sr   <= '1;
            resp_long <= 1'b0;
            rd_pend   <= 1'b0;
            rdaddr    <= 40'd0;
            dat_sr    <= 16'h0000;
            crc       <= '0;
        end else begin
            // cnt restarts on every state change; the start bit already counts as RX bit 0.
            if (state_nxt != state)  cnt <= (state_nxt == RX_CMD) ? 11'd1 : 11'd0;
            else if (state != RX_IDLE) cnt <= cnt + 11'd1;

            if (state == RX_IDLE || state == RX_CMD)
                rx_sr <= {rx_sr[45:0], sdcmdin};

            if (cmd_done && cmd_ok) begin
                acmd <= (cmd_idx == 6'd55);
                if (has_resp) begin
                    resp_sr   <= resp_val;
                    resp_long <= is_long;
                    rd_pend   <= is_read;
                    if (is_read) rdaddr <= {cmd_arg, 8'd0};
                end
            end

            if (state == TX_RESP)
                resp_sr <= {resp_sr[134:0], 1'b1};

            if (state == WAIT_NAC)
                crc <= '0;

            if (state == TX_DATA) begin
                // Word k is loaded on the edge ending nibble 4k, so it is in place for nibble 4k+1;
                // bumping rdaddr here gives the ROM four cycles to present the next word.
                if (cnt[1:0] == 2'b00 && cnt <= 11'd1020) begin
                    dat_sr       <= rddata;
                    rdaddr[7:0]  <= rdaddr[7:0] + 8'd1;
                end else begin
                    dat_sr <= {dat_sr[11:0], 4'h0};
                end
                if (cnt >= 11'd1 && cnt <= 11'd1024) begin
                    for (int j = 0; j < 4; j++)
                        crc[j] <= crc16_step(crc[j], dat_sr[12 + j]);
                end else if (cnt >= 11'd1025 && cnt <= 11'd1040) begin
                    for (int j = 0; j < 4; j++)
                        crc[j] <= {crc[j][14:0], 1'b0};
                end
            end
        end
    end

    logic [3:0] cur_dat;

    always_comb begin
        cur_dat = 4'hF;
        if (cnt == 11'd0)
            cur_dat = 4'h0;
        else if (cnt <= 11'd1024)
            cur_dat = dat_sr[15:12];
        else if (cnt <= 11'd1040)
            cur_dat = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
    end

    // Lines change on the falling edge so the host sees stable data at its rising edge.
    always_ff @(negedge sdclk or negedge rstn_async) begin
        if (!rstn_async) begin
            cmd_q  <= 1'b1;
            dat_oe <= 1'b0;
            dat_q  <= 4'hF;
        end else begin
            cmd_q  <= (state == TX_RESP) ? resp_sr[135] : 1'b1;
            dat_oe <= (state == TX_DATA);
            dat_q  <= cur_dat;
        end
    end

    assign sdcmdout = cmd_q;
    assign sddat    = dat_oe ? dat_q : 4'bzzzz;

endmodule

// File: tb/tb_sd_card_model.sv
// Testbench for sd_card_model: random and directed host commands against a command-table reference model.
// Latency: checks response start NCR+1 samples after the end bit and data start NAC+1 samples after the response.
// Backpressure: none; the bench acts as SD host plus a one-cycle synchronous ROM.
module tb_sd_card_model;

    logic        sdclk = 1'b0;
    logic        rstn_async = 1'b0;
    logic        sdcmdin = 1'b1;
    logic        sdcmdout;
    wire  [3:0]  sddat;
    logic [39:0] rdaddr;
    logic [15:0] rddata;

    pullup (sddat[0]);
    pullup (sddat[1]);
    pullup (sddat[2]);
    pullup (sddat[3]);

    sd_card_model dut (
        .sdclk      (sdclk),
        .rstn_async (rstn_async),
        .sdcmdin    (sdcmdin),
        .sdcmdout   (sdcmdout),
        .sddat      (sddat),
        .rdaddr     (rdaddr),
        .rddata     (rddata)
    );

    always #5 sdclk = ~sdclk;

    int          total = 0;
    int          bad = 0;
    logic        acmd_m = 1'b0;
    int          nblk = 0;
    logic [39:0] prev_addr;
    int          steps;
    int          bsteps;

    function automatic logic [15:0] rom_word(input logic [31:0] blk, input logic [7:0] w);
        return {8'h00, w} + blk[15:0] * 16'd257;
    endfunction

    always @(posedge sdclk) rddata <= rom_word(rdaddr[39:8], rdaddr[7:0]);

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--)
            c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction

    function automatic logic [135:0] r48(input logic [5:0] idx, input logic [31:0] pl);
        logic [39:0] h;
        h = {2'b00, idx, pl};
        return {h, crc7(h), 1'b1, {88{1'b1}}};
    endfunction

    // Command table: returns response length in bits (0 = silent) and the left-aligned response.
    function automatic int model_resp(input logic [5:0] idx, input logic [31:0] arg, input logic ac,
                                      output logic [135:0] r);
        r = '1;
        case (idx)
            6'd2, 6'd10: begin r = {2'b00, 6'h3F, 127'h0, 1'b1}; return 136; end
            6'd3:  begin r = r48(idx, 32'h0013_0500); return 48; end
            6'd7, 6'd16, 6'd55, 6'd17: begin r = r48(idx, 32'h0000_0900); return 48; end
            6'd8:  begin r = r48(idx, {20'h0, arg[11:0]}); return 48; end
            6'd41: begin
                if (ac) begin
                    r = {2'b00, 6'h3F, 32'hC0FF8000, 7'h7F, 1'b1, {88{1'b1}}};
                    return 48;
                end
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    // fault: 0 good, 1 CRC bit flipped, 2 direction bit 0, 3 end bit 0.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input int fault);
        logic [39:0] h;
        logic [47:0] w;
        h = {1'b0, (fault == 2) ? 1'b0 : 1'b1, idx, arg};
        w = {h, crc7(h), (fault == 3) ? 1'b0 : 1'b1};
        if (fault == 1) w[1] = ~w[1];
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdclk);
            sdcmdin = w[i];
        end
        @(posedge sdclk);
        @(negedge sdclk);
        sdcmdin = 1'b1;
    endtask

    task automatic get_resp(input int len, output logic [135:0] r, output int lat);
        r = '1;
        lat = 0;
        for (int n = 1; n <= 64 && lat == 0; n++) begin
            @(posedge sdclk); #1;
            if (sdcmdout === 1'b0) lat = n;
        end
        if (lat == 0) return;
        r[135] = 1'b0;
        for (int i = 1; i < len; i++) begin
            @(posedge sdclk); #1;
            r[135 - i] = sdcmdout;
        end
    endtask

    task automatic expect_quiet(input int n, input string tag);
        int busy;
        busy = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge sdclk); #1;
            if (sdcmdout !== 1'b1 || sddat !== 4'hF) busy++;
        end
        chk(tag, 136'(busy), 136'(0));
    endtask

    task automatic track_addr();
        logic [7:0] nx;
        if (rdaddr !== prev_addr) begin
            nx = prev_addr[7:0] + 8'd1;
            if (rdaddr === {prev_addr[39:8], nx}) steps++;
            else bsteps++;
            prev_addr = rdaddr;
        end
    endtask

    task automatic read_block(input logic [31:0] arg);
        logic [3:0]  nib [1024];
        logic [15:0] ecrc [4];
        logic [15:0] gcrc [4];
        logic [3:0]  got [1042];
        logic [15:0] w;
        int lat, errs, cmd_busy;
        nblk++;
        for (int k = 0; k < 256; k++) begin
            w = rom_word(arg, k[7:0]);
            nib[4*k]     = w[15:12];
            nib[4*k + 1] = w[11:8];
            nib[4*k + 2] = w[7:4];
            nib[4*k + 3] = w[3:0];
        end
        for (int j = 0; j < 4; j++) begin
            ecrc[j] = 16'h0000;
            for (int i = 0; i < 1024; i++)
                ecrc[j] = {ecrc[j][14:0], 1'b0} ^ ((nib[i][j] ^ ecrc[j][15]) ? 16'h1021 : 16'h0000);
        end
        prev_addr = {arg, 8'h00};
        steps = 0;
        bsteps = 0;
        lat = 0;
        for (int n = 1; n <= 16 && lat == 0; n++) begin
            @(posedge sdclk); #1;
            track_addr();
            if (sddat !== 4'hF) lat = n;
        end
        chk("blk_lat", 136'(lat), 136'(3));
        if (lat == 0) return;
        got[0] = sddat;
        cmd_busy = 0;
        for (int i = 1; i < 1042; i++) begin
            @(posedge sdclk); #1;
            track_addr();
            got[i] = sddat;
            if (sdcmdout !== 1'b1) cmd_busy++;
        end
        errs = 0;
        for (int i = 0; i < 1024; i++)
            if (got[i + 1] !== nib[i]) errs++;
        for (int b = 0; b < 16; b++)
            for (int j = 0; j < 4; j++)
                gcrc[j][15 - b] = got[1025 + b][j];
        chk("blk_start", 136'(got[0]), 136'(4'h0));
        chk("blk_data_err", 136'(errs), 136'(0));
        for (int j = 0; j < 4; j++)
            chk($sformatf("blk_crc%0d", j), 136'(gcrc[j]), 136'(ecrc[j]));
        chk("blk_end", 136'(got[1041]), 136'(4'hF));
        chk("blk_cmd_idle", 136'(cmd_busy), 136'(0));
        chk("blk_addr_steps", 136'(steps), 136'(256));
        chk("blk_addr_bad", 136'(bsteps), 136'(0));
        chk("blk_addr_end", 136'(rdaddr), 136'({arg, 8'h00}));
        expect_quiet(8, "blk_release");
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int fault, input bit rd_blk);
        logic [135:0] exp_r, got_r;
        int len, lat;
        send_cmd(idx, arg, fault);
        len = 0;
        exp_r = '1;
        if (fault == 0) begin
            len = model_resp(idx, arg, acmd_m, exp_r);
            acmd_m = (idx == 6'd55);
        end
        if (len == 0) begin
            expect_quiet(20, $sformatf("c%0d_f%0d_quiet", idx, fault));
        end else begin
            get_resp(len, got_r, lat);
            chk($sformatf("c%0d_lat", idx), 136'(lat), 136'(3));
            chk($sformatf("c%0d_resp", idx), got_r, exp_r);
            if (idx == 6'd17) begin
                chk("c17_rdaddr", 136'(rdaddr), 136'({arg, 8'h00}));
                if (rd_blk) read_block(arg);
            end else begin
                expect_quiet(6, $sformatf("c%0d_after", idx));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int picks [14] = '{0, 2, 3, 7, 8, 10, 16, 55, 41, 41, 55, 5, 9, 17};
        int idx, f;

        // Reset
        @(negedge sdclk);
        @(negedge sdclk);
        chk("rst_cmd", 136'(sdcmdout), 136'(1'b1));
        chk("rst_dat", 136'(sddat), 136'(4'hF));
        chk("rst_addr", 136'(rdaddr), 136'(0));
        rstn_async = 1'b1;
        repeat (4) @(negedge sdclk);

        // Directed
        send_cmd(6'd0, 32'h0, 0);
        acmd_m = 1'b0;
        expect_quiet(100, "cmd0_quiet");
        do_cmd(6'd7, 32'h0013_0000, 0, 1);
        do_cmd(6'd7, 32'h0013_0000, 1, 1);
        do_cmd(6'd8, 32'h0000_01AA, 0, 1);
        do_cmd(6'd55, 32'h0013_0000, 0, 1);
        do_cmd(6'd41, 32'h40FF_8000, 0, 1);
        do_cmd(6'd41, 32'h40FF_8000, 0, 1);
        do_cmd(6'd2, 32'h0, 0, 1);
        do_cmd(6'd3, 32'h0, 0, 1);
        do_cmd(6'd7, 32'h0013_0000, 2, 1);
        do_cmd(6'd7, 32'h0013_0000, 3, 1);
        do_cmd(6'd17, 32'h0, 0, 1);

        // Random command mix
        for (int t = 0; t < 40; t++) begin
            idx = picks[$urandom_range(0, 13)];
            f = $urandom_range(0, 5);
            if (f > 3) f = 0;
            if (idx == 17 && nblk >= 3) idx = 8;
            do_cmd(6'(idx), $urandom, f, 1);
            repeat ($urandom_range(0, 5)) @(posedge sdclk);
        end

        // Reset in the middle of a block
        do_cmd(6'd17, 32'h0000_0ABC, 0, 0);
        repeat (200) @(posedge sdclk);
        #3 rstn_async = 1'b0;
        #1;
        chk("mid_rst_cmd", 136'(sdcmdout), 136'(1'b1));
        chk("mid_rst_dat", 136'(sddat), 136'(4'hF));
        chk("mid_rst_addr", 136'(rdaddr), 136'(0));
        @(negedge sdclk);
        @(negedge sdclk);
        rstn_async = 1'b1;
        acmd_m = 1'b0;
        expect_quiet(50, "post_rst_quiet");
        do_cmd(6'd8, 32'h0000_03C5, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
